// File: rtl/ghost_mode_scheduler_pkg.sv
// Ghost scheduler shared types, timing constants
// and the scatter/chase phase table.
package ghost_mode_scheduler_pkg;

    localparam int FPS           = 60;
    localparam int SCATTER_LONG  = 7;
    localparam int SCATTER_SHORT = 5;
    localparam int CHASE_SECS    = 20;
    localparam int FRIGHT_SECS   = 10;
    localparam int FLASH_SECS    = 3;
    localparam int INKY_DOTS     = 30;
    localparam int CLYDE_DOTS    = 60;
    localparam int HOUSE_TMO     = 4;

    typedef enum logic [1:0] {
        MODE_WAIT    = 2'd0,
        MODE_SCATTER = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_FRIGHT  = 2'd3
    } ghost_mode_t;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_RUN,
        TOP_FRIGHT
    } top_state_t;

    typedef enum logic [1:0] {
        G_HOUSE,
        G_ACTIVE,
        G_DEAD
    } ghost_state_t;

    // Zero means the phase never expires (last chase).
    function automatic logic [6:0] phase_secs(
        input logic [1:0]  round,
        input ghost_mode_t phase
    );
        logic [6:0] s;
        if (phase == MODE_CHASE)
            s = (round == 2'd3) ? 7'd0 : 7'(CHASE_SECS);
        else if (round < 2'd2)
            s = 7'(SCATTER_LONG);
        else
            s = 7'(SCATTER_SHORT);
        return s;
    endfunction

    // Dot quota of the one-hot house ghost next in line.
    function automatic logic [5:0] release_dots(
        input logic [3:0] tgt
    );
        logic [5:0] n;
        n = 6'd0;
        unique case (1'b1)
            tgt[2]:  n = 6'(INKY_DOTS);
            tgt[3]:  n = 6'(CLYDE_DOTS);
            default: n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Game-control <-> ghost scheduler bundle.
// master = game control, slave = scheduler.
interface ghost_mode_scheduler_if;

    logic        soft_reset;
    logic        new_map;
    logic        level_start;
    logic        power_pellet;
    logic        dot_eaten;
    logic [3:0]  ghost_hit;
    logic [3:0]  ghost_home;
    logic [7:0]  ghost_mode;
    logic [3:0]  ghost_dead;
    logic [3:0]  ghost_release;
    logic        reverse;
    logic        flash;
    logic        pacman_killed;
    logic [10:0] score_add;

    modport master (
        output soft_reset, new_map, level_start,
        output power_pellet, dot_eaten,
        output ghost_hit, ghost_home,
        input  ghost_mode, ghost_dead, ghost_release,
        input  reverse, flash, pacman_killed, score_add
    );

    modport slave (
        input  soft_reset, new_map, level_start,
        input  power_pellet, dot_eaten,
        input  ghost_hit, ghost_home,
        output ghost_mode, ghost_dead, ghost_release,
        output reverse, flash, pacman_killed, score_add
    );

endinterface

// File: rtl/ghost_mode_scheduler_sec_timer.sv
// Frame-tick seconds counter: ticks 0..FPS-1,
// seconds advance on the wrap.
module ghost_mode_scheduler_sec_timer
    import ghost_mode_scheduler_pkg::*;
(
    input  logic       frame_clk,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] tick_cnt,
    output logic [6:0] secs
);

    // Clear wins over count; hold when disabled.
    always_ff @(posedge frame_clk) begin
        if (clr) begin
            tick_cnt <= '0;
            secs     <= '0;
        end else if (en) begin
            if (tick_cnt == 6'(FPS - 1)) begin
                tick_cnt <= '0;
                secs     <= secs + 7'd1;
            end else begin
                tick_cnt <= tick_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Central ghost scheduler: phase table, fright
// window, house release order and eat combo.
module ghost_mode_scheduler
    import ghost_mode_scheduler_pkg::*;
(
    input  logic frame_clk,
    input  logic Reset,
    ghost_mode_scheduler_if.slave bus
);

    top_state_t   top_q;
    ghost_mode_t  phase_q;
    ghost_state_t gst_q [4];
    logic [1:0]   round_q;
    logic [1:0]   combo_q;
    logic [3:0]   eaten_q;
    logic [5:0]   dot_q;
    logic [3:0]   rel_q;
    logic         rev_q;
    logic         killed_q;
    logic [10:0]  score_q;

    logic [5:0]   ph_tick, fr_tick, ho_tick;
    logic [6:0]   ph_secs, fr_secs, ho_secs;

    logic         rst_any, in_play, pp;
    logic         ph_en, ph_exp, ph_clr;
    logic         fr_en, fr_exp, fr_clr;
    logic         ho_en, ho_exp, ho_clr;
    logic [6:0]   ph_dur;
    logic [3:0]   act_v, house_v, dead_v;
    logic [3:0]   fr_v, eat_v, eat_oh, tgt_oh;
    logic [3:0]   rel_now;
    logic [5:0]   dot_lim;
    logic         dot_rel, rel_go, kill;
    logic [1:0]   combo_use;
    logic [7:0]   mode_c;

    assign rst_any = Reset | bus.soft_reset | bus.new_map;
    assign in_play = (top_q != TOP_IDLE);
    assign pp      = bus.power_pellet & in_play;

    // A pellet freezes the phase timer in that frame,
    // so it also masks a coincident phase expiry.
    assign ph_dur = phase_secs(round_q, phase_q);
    assign ph_en  = (top_q == TOP_RUN) & ~pp;
    assign ph_exp = ph_en & (ph_dur != 7'd0)
                  & (ph_tick == 6'(FPS - 1))
                  & (ph_secs + 7'd1 == ph_dur);
    assign ph_clr = rst_any | ~in_play | ph_exp;

    assign fr_en  = (top_q == TOP_FRIGHT);
    assign fr_exp = fr_en & ~pp
                  & (fr_tick == 6'(FPS - 1))
                  & (fr_secs + 7'd1 == 7'(FRIGHT_SECS));
    assign fr_clr = rst_any | pp | ~fr_en;

    assign ho_en  = in_play & (|house_v);
    assign ho_exp = ho_en
                  & (ho_tick == 6'(FPS - 1))
                  & (ho_secs + 7'd1 == 7'(HOUSE_TMO));
    assign ho_clr = rst_any | ~in_play
                  | bus.dot_eaten | rel_go;

    ghost_mode_scheduler_sec_timer u_phase_tmr (
        .frame_clk (frame_clk),
        .clr       (ph_clr),
        .en        (ph_en),
        .tick_cnt  (ph_tick),
        .secs      (ph_secs)
    );

    ghost_mode_scheduler_sec_timer u_fright_tmr (
        .frame_clk (frame_clk),
        .clr       (fr_clr),
        .en        (fr_en),
        .tick_cnt  (fr_tick),
        .secs      (fr_secs)
    );

    ghost_mode_scheduler_sec_timer u_house_tmr (
        .frame_clk (frame_clk),
        .clr       (ho_clr),
        .en        (ho_en),
        .tick_cnt  (ho_tick),
        .secs      (ho_secs)
    );

    // Per-ghost state flags.
    always_comb begin
        act_v   = '0;
        house_v = '0;
        dead_v  = '0;
        for (int i = 0; i < 4; i++) begin
            act_v[i]   = (gst_q[i] == G_ACTIVE);
            house_v[i] = (gst_q[i] == G_HOUSE);
            dead_v[i]  = (gst_q[i] == G_DEAD);
        end
    end

    // A pellet this frame makes every active ghost
    // edible at once, even ones eaten earlier.
    assign fr_v = act_v
                & ({4{pp}}
                 | ({4{fr_en}} & ~eaten_q));
    assign eat_v  = bus.ghost_hit & fr_v;
    assign eat_oh = eat_v & (~eat_v + 4'd1);
    assign kill   = in_play
                  & (|(bus.ghost_hit & act_v & ~fr_v));
    assign combo_use = pp ? 2'd0 : combo_q;

    assign tgt_oh  = house_v & (~house_v + 4'd1);
    assign dot_lim = release_dots(tgt_oh);
    assign dot_rel = in_play & bus.dot_eaten
                   & (dot_lim != 6'd0)
                   & (dot_q == dot_lim - 6'd1);
    assign rel_go  = dot_rel | ho_exp;

    assign rel_now = (top_q == TOP_IDLE && bus.level_start)
                   ? 4'b0011
                   : (rel_go ? tgt_oh : 4'b0000);

    // Displayed mode per ghost from registered state.
    always_comb begin
        mode_c = '0;
        for (int i = 0; i < 4; i++) begin
            unique case (gst_q[i])
                G_HOUSE:
                    mode_c[2*i +: 2] = MODE_WAIT;
                G_ACTIVE:
                    mode_c[2*i +: 2] = (fr_en && !eaten_q[i])
                                     ? MODE_FRIGHT : phase_q;
                default:
                    mode_c[2*i +: 2] = phase_q;
            endcase
        end
    end

    // Top, per-ghost FSMs and registered pulses.
    always_ff @(posedge frame_clk) begin
        if (rst_any) begin
            top_q    <= TOP_IDLE;
            phase_q  <= MODE_WAIT;
            round_q  <= '0;
            combo_q  <= '0;
            eaten_q  <= '0;
            dot_q    <= '0;
            rel_q    <= '0;
            rev_q    <= 1'b0;
            killed_q <= 1'b0;
            score_q  <= '0;
            for (int i = 0; i < 4; i++)
                gst_q[i] <= (i == 0) ? G_ACTIVE : G_HOUSE;
        end else begin
            rev_q   <= 1'b0;
            rel_q   <= rel_now;
            score_q <= '0;

            unique case (top_q)
                TOP_IDLE: begin
                    if (bus.level_start) begin
                        top_q   <= TOP_RUN;
                        phase_q <= MODE_SCATTER;
                    end
                end
                TOP_RUN: begin
                    if (pp) begin
                        top_q   <= TOP_FRIGHT;
                        combo_q <= '0;
                        rev_q   <= 1'b1;
                    end else if (ph_exp) begin
                        rev_q <= 1'b1;
                        if (phase_q == MODE_CHASE) begin
                            phase_q <= MODE_SCATTER;
                            if (round_q != 2'd3)
                                round_q <= round_q + 2'd1;
                        end else begin
                            phase_q <= MODE_CHASE;
                        end
                    end
                end
                TOP_FRIGHT: begin
                    if (pp) begin
                        combo_q <= '0;
                        rev_q   <= 1'b1;
                    end else if (fr_exp) begin
                        top_q   <= TOP_RUN;
                        combo_q <= '0;
                    end
                end
                default: top_q <= TOP_IDLE;
            endcase

            if (|eat_oh) begin
                score_q <= 11'd200 << combo_use;
                combo_q <= (combo_use == 2'd3)
                         ? 2'd3 : combo_use + 2'd1;
            end
            eaten_q <= (pp ? 4'b0000 : eaten_q) | eat_oh;

            if (kill)
                killed_q <= 1'b1;

            if (rel_go)
                dot_q <= '0;
            else if (in_play && bus.dot_eaten && |house_v)
                dot_q <= dot_q + 6'd1;

            for (int i = 0; i < 4; i++) begin
                unique case (gst_q[i])
                    G_HOUSE:
                        if (rel_now[i])
                            gst_q[i] <= G_ACTIVE;
                    G_ACTIVE:
                        if (eat_oh[i])
                            gst_q[i] <= G_DEAD;
                    G_DEAD:
                        if (bus.ghost_home[i])
                            gst_q[i] <= G_ACTIVE;
                    default:
                        gst_q[i] <= G_HOUSE;
                endcase
            end
        end
    end

    assign bus.ghost_mode    = mode_c;
    assign bus.ghost_dead    = dead_v;
    assign bus.ghost_release = rel_q;
    assign bus.reverse       = rev_q;
    assign bus.pacman_killed = killed_q;
    assign bus.score_add     = score_q;
    assign bus.flash         = fr_en
        && (fr_secs >= 7'(FRIGHT_SECS - FLASH_SECS));

endmodule
